// File: rtl/ne_fp_shf_pipe.sv
// Pipelined barrel shifter with valid/ready handshake and sticky-bit capture.
// The log2 shift network is split evenly across NUM_STG register stages, low shift bits first.
module ne_fp_shf_pipe #(
   parameter int BW_DATA = 33,
   parameter int BW_SF   = 6,
   parameter int SIGNED  = 0,
   parameter int NUM_STG = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [BW_DATA-1:0] a,
   input  logic [BW_SF-1:0]   s,
   input  logic               dir,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [BW_DATA-1:0] z,
   output logic               sticky
);

   localparam int LST = NUM_STG - 1;

   // One binary shift step; a step of BW_DATA or more leaves only fill.
   function automatic logic [BW_DATA-1:0] shf_dat(input logic [BW_DATA-1:0] d,
                                                   input int sh, input logic dr);
      logic                   fill;
      logic [2*BW_DATA-1:0]   ext;
      fill = (SIGNED != 0) && dr && d[BW_DATA-1];
      ext  = {{BW_DATA{fill}}, d};
      if (sh >= BW_DATA) begin
         shf_dat = {BW_DATA{fill}};
      end else if (!dr) begin
         shf_dat = d << sh;
      end else begin
         ext     = ext >> sh;
         shf_dat = ext[BW_DATA-1:0];
      end
   endfunction

   // Fill bits only reach the far end once the total shift covers the word, where
   // sticky must be OR(a) anyway; a signed fill equals a's MSB, so this stays exact.
   function automatic logic shf_stk(input logic [BW_DATA-1:0] d,
                                    input int sh, input logic dr);
      logic st;
      st = 1'b0;
      for (int j = 0; j < BW_DATA; j++) begin
         if (dr ? (j < sh) : (j >= BW_DATA - sh)) st = st | d[j];
      end
      return st;
   endfunction

   logic [NUM_STG-1:0] vld_q, vld_d, stk_q, stk_d, adv;
   logic [BW_DATA-1:0] dat_q [NUM_STG];
   logic [BW_DATA-1:0] dat_d [NUM_STG];
   logic [BW_SF-1:0]   sft_q [NUM_STG];
   logic [BW_SF-1:0]   sft_d [NUM_STG];
   logic               dir_q [NUM_STG];
   logic               dir_d [NUM_STG];

   always_comb begin
      logic               rdy_acc;
      logic               vw, drw, stw;
      logic [BW_DATA-1:0] dw;
      logic [BW_SF-1:0]   sw;
      int                 kp;
      adv     = '0;
      vld_d   = vld_q;
      stk_d   = stk_q;
      dat_d   = dat_q;
      sft_d   = sft_q;
      dir_d   = dir_q;
      rdy_acc = out_rdy;
      for (int k = LST; k >= 0; k--) begin
         rdy_acc = !vld_q[k] || rdy_acc;
         adv[k]  = rdy_acc;
      end
      in_rdy = adv[0] && !rst;
      for (int k = 0; k < NUM_STG; k++) begin
         kp = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            vw = in_vld && in_rdy; dw = a; sw = s; drw = dir; stw = 1'b0;
         end else begin
            vw = vld_q[kp]; dw = dat_q[kp]; sw = sft_q[kp]; drw = dir_q[kp]; stw = stk_q[kp];
         end
         for (int i = 0; i < BW_SF; i++) begin
            if (i >= k * BW_SF / NUM_STG && i < (k + 1) * BW_SF / NUM_STG && sw[i]) begin
               stw = stw | shf_stk(dw, 1 << i, drw);
               dw  = shf_dat(dw, 1 << i, drw);
            end
         end
         if (adv[k]) begin
            vld_d[k] = vw;
            dat_d[k] = dw;
            sft_d[k] = sw;
            dir_d[k] = drw;
            stk_d[k] = stw;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         stk_q <= '0;
         for (int k = 0; k < NUM_STG; k++) begin
            dat_q[k] <= '0;
            sft_q[k] <= '0;
            dir_q[k] <= 1'b0;
         end
      end else begin
         vld_q <= vld_d;
         stk_q <= stk_d;
         for (int k = 0; k < NUM_STG; k++) begin
            dat_q[k] <= dat_d[k];
            sft_q[k] <= sft_d[k];
            dir_q[k] <= dir_d[k];
         end
      end
   end

   assign out_vld = vld_q[LST];
   assign z       = dat_q[LST];
   assign sticky  = stk_q[LST];

endmodule

// File: tb/tb_ne_fp_shf_pipe.sv
// Scoreboard bench for ne_fp_shf_pipe: unsigned and signed instances share one stimulus stream.
module tb_ne_fp_shf_pipe;

   localparam int BW = 33;
   localparam int BS = 6;
   localparam int NS = 2;

   logic          clk = 1'b0;
   logic          rst, in_vld, dir, out_rdy;
   logic          in_rdy0, in_rdy1, out_vld0, out_vld1, st0, st1;
   logic [BW-1:0] a, z0, z1;
   logic [BS-1:0] s;

   always #5 clk = ~clk;

   ne_fp_shf_pipe #(.BW_DATA(BW), .BW_SF(BS), .SIGNED(0), .NUM_STG(NS)) u_dut_u (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy0), .a(a), .s(s), .dir(dir),
      .out_vld(out_vld0), .out_rdy(out_rdy), .z(z0), .sticky(st0));

   ne_fp_shf_pipe #(.BW_DATA(BW), .BW_SF(BS), .SIGNED(1), .NUM_STG(NS)) u_dut_s (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy1), .a(a), .s(s), .dir(dir),
      .out_vld(out_vld1), .out_rdy(out_rdy), .z(z1), .sticky(st1));

   typedef struct {
      logic [BW-1:0] z0, z1;
      logic          st0, st1;
      int            t_in;
      logic          lat;
   } exp_t;

   exp_t          sbq[$];
   int            n_vec = 0, n_err = 0, cyc = 0, n_acc = 0, n_out = 0;
   logic          lit_en = 1'b0, lat_en = 1'b0, hold_pend = 1'b0, last_out = 1'b0;
   logic [BW-1:0] lit_z0, lit_z1, hold_z0, hold_z1;
   logic          lit_st0, lit_st1, hold_s0, hold_s1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference: whole shift in one go on a double-width word, returns {sticky, z}.
   function automatic logic [BW:0] ref_shf(input logic [BW-1:0] ai, input int sh,
                                           input logic dr, input logic sgn);
      logic [2*BW-1:0] ext;
      logic [63:0]     mask;
      logic [BW-1:0]   zr;
      logic            sr, fill;
      fill = sgn && dr && ai[BW-1];
      if (sh >= BW) begin
         zr = {BW{fill}};
         sr = |ai;
      end else if (!dr) begin
         ext = {{BW{1'b0}}, ai} << sh;
         zr  = ext[BW-1:0];
         sr  = |ext[2*BW-1:BW];
      end else begin
         ext  = {{BW{fill}}, ai} >> sh;
         zr   = ext[BW-1:0];
         mask = (64'd1 << sh) - 64'd1;
         sr   = |({{(64-BW){1'b0}}, ai} & mask);
      end
      return {sr, zr};
   endfunction

   // One clock: evaluate this cycle's handshakes just after the falling edge, then advance.
   task automatic step(output logic took);
      exp_t        e;
      logic [BW:0] r0, r1;
      #1;
      if (hold_pend && out_vld0) begin
         chk("hold_z_u", z0, hold_z0);
         chk("hold_st_u", st0, hold_s0);
         chk("hold_z_s", z1, hold_z1);
         chk("hold_st_s", st1, hold_s1);
      end
      hold_pend = out_vld0 && !out_rdy;
      hold_z0 = z0; hold_z1 = z1; hold_s0 = st0; hold_s1 = st1;
      took = in_vld && in_rdy0;
      if (took) begin
         if (lit_en) begin
            e.z0 = lit_z0; e.st0 = lit_st0; e.z1 = lit_z1; e.st1 = lit_st1;
         end else begin
            r0 = ref_shf(a, int'(s), dir, 1'b0);
            r1 = ref_shf(a, int'(s), dir, 1'b1);
            e.z0 = r0[BW-1:0]; e.st0 = r0[BW]; e.z1 = r1[BW-1:0]; e.st1 = r1[BW];
         end
         e.t_in = cyc;
         e.lat  = lat_en;
         sbq.push_back(e);
         n_acc++;
      end
      last_out = out_vld0 && out_rdy;
      if (last_out) begin
         n_out++;
         if (sbq.size() == 0) begin
            chk("spurious_out", {63'b0, out_vld0}, 64'd0);
         end else begin
            e = sbq.pop_front();
            chk("z_u", z0, e.z0);
            chk("st_u", st0, e.st0);
            chk("z_s", z1, e.z1);
            chk("st_s", st1, e.st1);
            chk("vld_s", out_vld1, 1);
            if (e.lat) chk("latency", cyc - e.t_in, NS);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic send(input logic [BW-1:0] ai, input logic [BS-1:0] si, input logic di);
      logic took;
      a = ai; s = si; dir = di; in_vld = 1'b1;
      took = 1'b0;
      for (int b = 0; b < 50 && !took; b++) step(took);
      chk("send_accept", took, 1);
      in_vld = 1'b0;
   endtask

   task automatic drain();
      logic took;
      in_vld = 1'b0; out_rdy = 1'b1;
      for (int b = 0; b < 200 && sbq.size() != 0; b++) step(took);
      chk("drain_empty", sbq.size(), 0);
   endtask

   task automatic run_lit(input logic [BW-1:0] ai, input logic [BS-1:0] si, input logic di,
                          input logic [BW-1:0] ez0, input logic es0,
                          input logic [BW-1:0] ez1, input logic es1);
      lit_en = 1'b1; lat_en = 1'b1; out_rdy = 1'b1;
      lit_z0 = ez0; lit_st0 = es0; lit_z1 = ez1; lit_st1 = es1;
      send(ai, si, di);
      drain();
      lit_en = 1'b0; lat_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic          took;
      logic [63:0]   rw;
      int            n0, o0;
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; a = '0; s = '0; dir = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_rdy", in_rdy0, 0);
      chk("rst_out_vld", out_vld0, 0);
      chk("rst_z", z0, 0);
      chk("rst_sticky", st0, 0);
      chk("rst_z_s", z1, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_rdy", in_rdy0, 1);
      @(negedge clk);

      run_lit(33'h1_0000_0001, 6'd1,  1'b0, 33'h0_0000_0002, 1'b1, 33'h0_0000_0002, 1'b1);
      run_lit(33'h1_0000_0000, 6'd4,  1'b1, 33'h0_1000_0000, 1'b0, 33'h1_F000_0000, 1'b0);
      run_lit(33'h0_0000_0005, 6'd40, 1'b1, 33'h0,           1'b1, 33'h0,           1'b1);
      run_lit(33'h1_2345_6789, 6'd0,  1'b1, 33'h1_2345_6789, 1'b0, 33'h1_2345_6789, 1'b0);
      run_lit(33'h0_0000_0005, 6'd0,  1'b0, 33'h0_0000_0005, 1'b0, 33'h0_0000_0005, 1'b0);
      run_lit(33'h1_2345_6789, 6'd63, 1'b0, 33'h0,           1'b1, 33'h0,           1'b1);
      run_lit(33'h1_0000_0000, 6'd33, 1'b1, 33'h0,           1'b1, 33'h1_FFFF_FFFF, 1'b1);
      run_lit(33'h1_8000_0001, 6'd32, 1'b1, 33'h0_0000_0001, 1'b1, 33'h1_FFFF_FFFF, 1'b1);
      run_lit(33'h0_FFFF_FFFF, 6'd1,  1'b0, 33'h1_FFFF_FFFE, 1'b0, 33'h1_FFFF_FFFE, 1'b0);
      run_lit(33'h0_8000_0010, 6'd4,  1'b1, 33'h0_0800_0001, 1'b0, 33'h0_0800_0001, 1'b0);

      // Backpressure: three back-to-back offers into a blocked pipe.
      out_rdy = 1'b0; n0 = n_acc; in_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = BW'(33'h1_0F0F_0F0F + i * 33'h111); s = BS'(i + 3); dir = i[0];
         if (i == 2) begin
            #1;
            chk("bp_in_rdy_third", in_rdy0, 0);
         end
         step(took);
      end
      chk("bp_accepted", n_acc - n0, NS);
      repeat (3) step(took);
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(took);
         chk("bp_nogap", last_out, 1);
         if (took) in_vld = 1'b0;
      end
      drain();

      // Reset with two operands in flight.
      out_rdy = 1'b0;
      send(33'h1_5555_AAAA, 6'd7, 1'b1);
      send(33'h0_1234_5678, 6'd9, 1'b0);
      rst = 1'b1;
      step(took);
      sbq.delete();
      hold_pend = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_out_vld", out_vld0, 0);
      chk("mid_rst_z", z0, 0);
      chk("mid_rst_sticky", st0, 0);
      chk("mid_rst_in_rdy", in_rdy0, 1);
      out_rdy = 1'b1; o0 = n_out;
      repeat (6) step(took);
      chk("mid_rst_no_stale", n_out - o0, 0);
      run_lit(33'h1_0000_0003, 6'd2, 1'b0, 33'h0_0000_000C, 1'b1, 33'h0_0000_000C, 1'b1);

      // Random streaming with random valid/ready.
      n0 = n_acc;
      for (int c = 0; c < 60000 && (n_acc - n0) < 10000; c++) begin
         in_vld  = ($urandom % 4) != 0;
         out_rdy = ($urandom % 4) != 0;
         rw = {$urandom, $urandom};
         case ($urandom % 8)
            0: a = '0;
            1: a = '1;
            2: a = BW'(64'd1 << $urandom_range(0, BW - 1));
            default: a = rw[BW-1:0];
         endcase
         s   = ($urandom % 2) ? BS'($urandom_range(0, 40)) : BS'($urandom_range(0, 63));
         dir = $urandom % 2;
         step(took);
      end
      chk("rand_count", n_acc - n0, 10000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
